// File: rtl/axis_axi4lite_master_pkg.sv
// axis_axi4lite_master_pkg: opcodes, status bytes and FSM states for the byte-stream AXI4-Lite master.
package axis_axi4lite_master_pkg;
    localparam logic [7:0] OP_WRITE   = 8'h01;
    localparam logic [7:0] OP_READ    = 8'h02;
    localparam logic [7:0] ST_BADOP   = 8'hFF;
    localparam logic [7:0] ST_TIMEOUT = 8'hFE;
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WR_REQ, WR_RESP, RD_REQ, RD_RESP, SEND} state_t;
endpackage

// File: rtl/axis_axi4lite_master_byte_serializer.sv
// axis_axi4lite_master_byte_serializer: emits up to 5 bytes MSB-first as an AXI-Stream.
module axis_axi4lite_master_byte_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [39:0] data_i,
    input  logic [2:0]  len_i,
    output logic        tvalid_o,
    input  logic        tready_i,
    output logic [7:0]  tdata_o,
    output logic        done_o
);
    logic [39:0] data_q;
    logic [2:0]  len_q;
    assign tvalid_o = len_q != 3'd0;
    assign tdata_o  = data_q[39:32];
    assign done_o   = tvalid_o && tready_i && len_q == 3'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            len_q  <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            len_q  <= len_i;
        end else if (tvalid_o && tready_i) begin
            data_q <= {data_q[31:0], 8'h00};
            len_q  <= len_q - 3'd1;
        end
    end
endmodule

// File: rtl/axis_axi4lite_master.sv
// axis_axi4lite_master: decodes byte-stream command packets into single AXI4-Lite
// transactions and returns status/read data as a byte stream.
module axis_axi4lite_master
    import axis_axi4lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cmd_tvalid,
    output logic                  cmd_tready,
    input  logic [7:0]            cmd_tdata,
    output logic                  rsp_tvalid,
    input  logic                  rsp_tready,
    output logic [7:0]            rsp_tdata,
    output logic                  ctrl_awvalid,
    input  logic                  ctrl_awready,
    output logic [ADDR_WIDTH-1:0] ctrl_awaddr,
    output logic                  ctrl_wvalid,
    input  logic                  ctrl_wready,
    output logic [31:0]           ctrl_wdata,
    output logic [3:0]            ctrl_wstrb,
    input  logic                  ctrl_bvalid,
    output logic                  ctrl_bready,
    input  logic [1:0]            ctrl_bresp,
    output logic                  ctrl_arvalid,
    input  logic                  ctrl_arready,
    output logic [ADDR_WIDTH-1:0] ctrl_araddr,
    input  logic                  ctrl_rvalid,
    output logic                  ctrl_rready,
    input  logic [31:0]           ctrl_rdata,
    input  logic [1:0]            ctrl_rresp
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                  ld, ser_done, cmd_hs, in_axi;
    logic [39:0]           ld_data;
    logic [2:0]            ld_len;

    assign cmd_hs       = cmd_tvalid && cmd_tready;
    assign in_axi       = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    // Ready/drain strobes are gated by reset so they read 0 while areset is held.
    assign cmd_tready   = !areset && state_q inside {IDLE, GET_ADDR, GET_DATA};
    assign ctrl_bready  = !areset && state_q inside {IDLE, WR_RESP};
    assign ctrl_rready  = !areset && state_q inside {IDLE, RD_RESP};
    assign ctrl_awvalid = state_q == WR_REQ && !aw_done_q;
    assign ctrl_wvalid  = state_q == WR_REQ && !w_done_q;
    assign ctrl_wstrb   = {4{state_q == WR_REQ}};
    assign ctrl_arvalid = state_q == RD_REQ;
    assign ctrl_awaddr  = addr_q;
    assign ctrl_araddr  = addr_q;
    assign ctrl_wdata   = data_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        tmo_d     = in_axi ? tmo_q + 1'b1 : tmo_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ld        = 1'b0;
        ld_data   = '0;
        ld_len    = '0;
        case (state_q)
            IDLE: if (cmd_hs) begin
                if (cmd_tdata == OP_WRITE || cmd_tdata == OP_READ) begin
                    wr_d    = cmd_tdata == OP_WRITE;
                    cnt_d   = '0;
                    state_d = GET_ADDR;
                end else begin
                    ld      = 1'b1;
                    ld_data = {ST_BADOP, 32'h0};
                    ld_len  = 3'd1;
                    state_d = SEND;
                end
            end
            GET_ADDR: if (cmd_hs) begin
                addr_d = ADDR_WIDTH'({addr_q, cmd_tdata});
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd1) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = wr_q ? GET_DATA : RD_REQ;
                end
            end
            GET_DATA: if (cmd_hs) begin
                data_d = {data_q[23:0], cmd_tdata};
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    tmo_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_REQ;
                end
            end
            WR_REQ: begin
                aw_done_d = aw_done_q || ctrl_awready;
                w_done_d  = w_done_q || ctrl_wready;
                state_d   = aw_done_d && w_done_d ? WR_RESP : WR_REQ;
            end
            WR_RESP: if (ctrl_bvalid) begin
                ld      = 1'b1;
                ld_data = {6'b0, ctrl_bresp, 32'h0};
                ld_len  = 3'd1;
                state_d = SEND;
            end
            RD_REQ: state_d = ctrl_arready ? RD_RESP : RD_REQ;
            RD_RESP: if (ctrl_rvalid) begin
                ld      = 1'b1;
                ld_data = {6'b0, ctrl_rresp, ctrl_rdata};
                ld_len  = 3'd5;
                state_d = SEND;
            end
            SEND: state_d = ser_done ? IDLE : SEND;
        endcase
        // A response accepted on the final cycle wins over the abort.
        if (in_axi && tmo_q == TMO_LAST && !ld) begin
            ld      = 1'b1;
            ld_data = {ST_TIMEOUT, 32'h0};
            ld_len  = 3'd1;
            state_d = SEND;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            tmo_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tmo_q     <= tmo_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    axis_axi4lite_master_byte_serializer u_ser (
        .clk      (aclk),
        .rst      (areset),
        .load_i   (ld),
        .data_i   (ld_data),
        .len_i    (ld_len),
        .tvalid_o (rsp_tvalid),
        .tready_i (rsp_tready),
        .tdata_o  (rsp_tdata),
        .done_o   (ser_done)
    );
endmodule

// File: tb/tb_axis_axi4lite_master.sv
// tb_axis_axi4lite_master: randomized command traffic against a word-per-address
// slave and a reference memory; a monitor pops expected response bytes.
module tb_axis_axi4lite_master;
    logic        aclk, areset;
    logic        cmd_tvalid, cmd_tready, rsp_tvalid, rsp_tready;
    logic [7:0]  cmd_tdata, rsp_tdata;
    logic        ctrl_awvalid, ctrl_awready, ctrl_wvalid, ctrl_wready, ctrl_bvalid, ctrl_bready;
    logic        ctrl_arvalid, ctrl_arready, ctrl_rvalid, ctrl_rready;
    logic [11:0] ctrl_awaddr, ctrl_araddr;
    logic [31:0] ctrl_wdata, ctrl_rdata;
    logic [3:0]  ctrl_wstrb;
    logic [1:0]  ctrl_bresp, ctrl_rresp;

    axis_axi4lite_master #(.ADDR_WIDTH(12), .TIMEOUT(16)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_tdata(cmd_tdata),
        .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata),
        .ctrl_awvalid(ctrl_awvalid), .ctrl_awready(ctrl_awready), .ctrl_awaddr(ctrl_awaddr),
        .ctrl_wvalid(ctrl_wvalid), .ctrl_wready(ctrl_wready), .ctrl_wdata(ctrl_wdata), .ctrl_wstrb(ctrl_wstrb),
        .ctrl_bvalid(ctrl_bvalid), .ctrl_bready(ctrl_bready), .ctrl_bresp(ctrl_bresp),
        .ctrl_arvalid(ctrl_arvalid), .ctrl_arready(ctrl_arready), .ctrl_araddr(ctrl_araddr),
        .ctrl_rvalid(ctrl_rvalid), .ctrl_rready(ctrl_rready), .ctrl_rdata(ctrl_rdata), .ctrl_rresp(ctrl_rresp)
    );

    int total = 0, bad = 0;
    int aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0, rdy_mode = 0;
    int n_wr = 0, b_count = 0, r_count = 0;
    logic drop_r = 0, seen_split = 0;
    logic [1:0] resp_code = 0;
    logic [7:0]  exp_rsp[$];
    logic [11:0] exp_aw[$], exp_ar[$];
    logic [31:0] exp_w[$];
    logic [31:0] ref_mem[int];
    logic [31:0] slv_mem[4096];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s actual=%0h required=nothing", name, act);
    endtask

    initial begin
        aclk = 0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        rsp_tready = 1;
        forever begin
            @(posedge aclk);
            #1;
            rsp_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~rsp_tready : 1'($urandom_range(0, 1));
        end
    end

    // Behavioural slave: per-channel ready latencies, one word stored per address.
    int aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic aw_got, w_got, r_pend;
    logic [11:0] aw_a, r_a;
    logic [31:0] w_d;
    initial foreach (slv_mem[i]) slv_mem[i] = 0;
    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            {ctrl_awready, ctrl_wready, ctrl_arready, ctrl_bvalid, ctrl_rvalid} <= '0;
            {aw_got, w_got, r_pend} <= '0;
            {aw_cnt, w_cnt, ar_cnt, r_cnt} <= '0;
            ctrl_bresp <= 0; ctrl_rresp <= 0; ctrl_rdata <= 0;
        end else begin
            ctrl_awready <= 0; ctrl_wready <= 0; ctrl_arready <= 0;
            if (ctrl_awvalid && ctrl_awready) begin
                aw_got <= 1; aw_a <= ctrl_awaddr; aw_cnt <= 0;
                if (exp_aw.size() == 0) unexp("awaddr", 32'(ctrl_awaddr));
                else chk("awaddr", 128'(ctrl_awaddr), 128'(exp_aw.pop_front()));
            end else if (ctrl_awvalid && !aw_got) begin
                if (aw_cnt >= aw_lat) ctrl_awready <= 1; else aw_cnt <= aw_cnt + 1;
            end
            if (ctrl_wvalid && ctrl_wready) begin
                w_got <= 1; w_d <= ctrl_wdata; w_cnt <= 0;
                chk("wstrb", 128'(ctrl_wstrb), 128'hF);
                if (exp_w.size() == 0) unexp("wdata", ctrl_wdata);
                else chk("wdata", 128'(ctrl_wdata), 128'(exp_w.pop_front()));
            end else if (ctrl_wvalid && !w_got) begin
                if (w_cnt >= w_lat) ctrl_wready <= 1; else w_cnt <= w_cnt + 1;
            end
            if (aw_got && w_got && !ctrl_bvalid) begin
                slv_mem[aw_a] <= w_d; ctrl_bvalid <= 1; ctrl_bresp <= resp_code;
                aw_got <= 0; w_got <= 0;
            end
            if (ctrl_bvalid && ctrl_bready) begin
                ctrl_bvalid <= 0; b_count <= b_count + 1;
            end
            if (ctrl_arvalid && ctrl_arready) begin
                r_pend <= 1; r_a <= ctrl_araddr; r_cnt <= 0;
                if (exp_ar.size() == 0) unexp("araddr", 32'(ctrl_araddr));
                else chk("araddr", 128'(ctrl_araddr), 128'(exp_ar.pop_front()));
            end else if (ctrl_arvalid && !r_pend) begin
                if (ar_cnt >= ar_lat) begin ctrl_arready <= 1; ar_cnt <= 0; end
                else ar_cnt <= ar_cnt + 1;
            end
            if (r_pend && !drop_r && !ctrl_rvalid) begin
                if (r_cnt >= r_lat) begin
                    ctrl_rvalid <= 1; ctrl_rdata <= slv_mem[r_a]; ctrl_rresp <= resp_code; r_pend <= 0;
                end else r_cnt <= r_cnt + 1;
            end
            if (ctrl_rvalid && ctrl_rready) begin
                ctrl_rvalid <= 0; r_count <= r_count + 1;
            end
        end
    end

    // Valid must stay up until its handshake.
    logic aw_hold, w_hold, ar_hold;
    always @(posedge aclk or posedge areset) begin
        if (areset) {aw_hold, w_hold, ar_hold} <= '0;
        else begin
            if (aw_hold) chk("awvalid_held", 128'(ctrl_awvalid), 128'd1);
            if (w_hold) chk("wvalid_held", 128'(ctrl_wvalid), 128'd1);
            if (ar_hold) chk("arvalid_held", 128'(ctrl_arvalid), 128'd1);
            aw_hold <= ctrl_awvalid && !ctrl_awready;
            w_hold  <= ctrl_wvalid && !ctrl_wready;
            ar_hold <= ctrl_arvalid && !ctrl_arready;
        end
    end

    // Response monitor: sampled mid-cycle, pops the scoreboard on each accepted byte.
    logic hold_v = 0;
    logic [7:0] hold_d = 0;
    always @(negedge aclk) begin
        if (areset) hold_v <= 0;
        else begin
            if (hold_v) begin
                chk("rsp_hold_valid", 128'(rsp_tvalid), 128'd1);
                chk("rsp_hold_data", 128'(rsp_tdata), 128'(hold_d));
            end
            if (rsp_tvalid && rsp_tready) begin
                if (exp_rsp.size() == 0) unexp("rsp_extra", 32'(rsp_tdata));
                else chk("rsp_byte", 128'(rsp_tdata), 128'(exp_rsp.pop_front()));
            end
            if (ctrl_wvalid && !ctrl_awvalid) seen_split <= 1;
            hold_v <= rsp_tvalid && !rsp_tready;
            hold_d <= rsp_tdata;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        cmd_tvalid = 1;
        cmd_tdata = b;
        for (n = 0; n < 300; n++) begin
            @(negedge aclk);
            if (cmd_tready) break;
        end
        if (n == 300) unexp("cmd_tready_timeout", 32'(b));
        @(posedge aclk);
        #1;
        cmd_tvalid = 0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [1:0] rc);
        resp_code = rc;
        exp_aw.push_back(a[11:0]);
        exp_w.push_back(d);
        exp_rsp.push_back({6'b0, rc});
        ref_mem[int'(a[11:0])] = d;
        n_wr++;
        send_byte(8'h01); send_byte(a[15:8]); send_byte(a[7:0]);
        send_byte(d[31:24]); send_byte(d[23:16]); send_byte(d[15:8]); send_byte(d[7:0]);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [1:0] rc, input bit tmo);
        logic [31:0] rd;
        rd = ref_mem.exists(int'(a[11:0])) ? ref_mem[int'(a[11:0])] : 32'h0;
        resp_code = rc;
        exp_ar.push_back(a[11:0]);
        if (tmo) exp_rsp.push_back(8'hFE);
        else begin
            exp_rsp.push_back({6'b0, rc});
            exp_rsp.push_back(rd[31:24]); exp_rsp.push_back(rd[23:16]);
            exp_rsp.push_back(rd[15:8]);  exp_rsp.push_back(rd[7:0]);
        end
        send_byte(8'h02); send_byte(a[15:8]); send_byte(a[7:0]);
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 500; n++) begin
            @(negedge aclk);
            if (exp_rsp.size() == 0) break;
        end
        if (n == 500) unexp("rsp_wait_timeout", 32'(exp_rsp.size()));
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        int n, b0;
        logic [7:0] op;
        logic [15:0] a;
        areset = 1; cmd_tvalid = 0; cmd_tdata = 0;
        #1;
        chk("reset_outputs", 128'({cmd_tready, rsp_tvalid, rsp_tdata, ctrl_awvalid, ctrl_wvalid, ctrl_arvalid,
            ctrl_bready, ctrl_rready, ctrl_awaddr, ctrl_araddr, ctrl_wdata, ctrl_wstrb}), 128'd0);
        repeat (3) @(posedge aclk);
        #1;
        areset = 0;

        do_write(16'h0004, 32'hDEADBEEF, 2'b00);
        wait_done();
        do_read(16'h0004, 2'b00, 0);
        wait_done();

        b0 = b_count; seen_split = 0; aw_lat = 0; w_lat = 3;
        do_write(16'h0010, 32'h12345678, 2'b00);
        wait_done();
        chk("split_one_bresp", 128'(b_count - b0), 128'd1);
        chk("split_aw_before_w", 128'(seen_split), 128'd1);
        w_lat = 0;

        exp_rsp.push_back(8'hFF);
        send_byte(8'h07);
        do_read(16'h0000, 2'b00, 0);
        wait_done();

        rdy_mode = 1;
        do_read(16'h0010, 2'b00, 0);
        wait_done();
        rdy_mode = 0;

        drop_r = 1;
        do_read(16'h0004, 2'b00, 1);
        for (n = 0; n < 100; n++) begin
            @(negedge aclk);
            if (rsp_tvalid) break;
        end
        chk("timeout_latency", 128'(n), 128'd16);
        chk("timeout_arvalid", 128'(ctrl_arvalid), 128'd0);
        wait_done();
        b0 = r_count;
        drop_r = 0;
        repeat (6) @(posedge aclk);
        #1;
        chk("late_r_drained", 128'(r_count - b0), 128'd1);
        chk("late_rvalid_low", 128'(ctrl_rvalid), 128'd0);

        send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'hAA);
        areset = 1;
        #1;
        chk("midreset_outputs", 128'({cmd_tready, rsp_tvalid, rsp_tdata, ctrl_awvalid, ctrl_wvalid, ctrl_arvalid,
            ctrl_bready, ctrl_rready, ctrl_awaddr, ctrl_araddr, ctrl_wdata, ctrl_wstrb}), 128'd0);
        repeat (2) @(posedge aclk);
        #1;
        areset = 0;
        do_write(16'h0020, 32'hCAFEF00D, 2'b00);
        wait_done();
        do_read(16'h0020, 2'b00, 0);
        wait_done();

        for (int i = 0; i < 40; i++) begin
            aw_lat = $urandom_range(0, 4); w_lat = $urandom_range(0, 4);
            ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 4);
            rdy_mode = $urandom_range(0, 2);
            a = {4'($urandom_range(0, 15)), 12'($urandom_range(0, 7) * 4)};
            case ($urandom_range(0, 4))
                0, 1: do_write(a, $urandom, 2'($urandom_range(0, 3)));
                2, 3: do_read(a, 2'($urandom_range(0, 3)), 0);
                default: begin
                    do op = 8'($urandom_range(0, 255)); while (op == 8'h01 || op == 8'h02);
                    exp_rsp.push_back(8'hFF);
                    send_byte(op);
                end
            endcase
            wait_done();
        end
        rdy_mode = 0;
        repeat (5) @(posedge aclk);
        #1;
        chk("bresp_count", 128'(b_count), 128'(n_wr));
        chk("leftover_rsp", 128'(exp_rsp.size()), 128'd0);
        chk("leftover_axi", 128'(exp_aw.size() + exp_w.size() + exp_ar.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
